// File: rtl/pdm_audio_out.sv
// pdm_audio_out: PCM-to-PDM transmitter with first-order carry-out sigma-delta modulator,
// self-generated bit clock and a one-sample holding buffer behind a valid/ready handshake.
module pdm_audio_out #(
    parameter int CLK_DIV = 50,
    parameter int OSR     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        pdm_out,
    output logic        pdm_clk,
    output logic        pdm_sd,
    output logic        done,
    output logic        underrun
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          pdm_out_q, pdm_out_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          pdm_sd_q;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          tick, boundary, accept, load;
    logic [16:0]   sum;

    always_comb begin
        tick        = en && (div_cnt_q == DIV_LAST);
        boundary    = tick && (bit_cnt_q == BIT_LAST);
        accept      = sample_valid && !hold_full_q;
        load        = boundary && hold_full_q;
        sum         = {1'b0, acc_q} + {1'b0, active_q};
        div_cnt_d   = !en ? div_cnt_q : (tick ? '0 : div_cnt_q + DW'(1));
        bit_cnt_d   = !tick ? bit_cnt_q : (boundary ? '0 : bit_cnt_q + BW'(1));
        acc_d       = tick ? sum[15:0] : acc_q;
        pdm_out_d   = !en ? 1'b0 : (tick ? sum[16] : pdm_out_q);
        // Derived from the next count so the clock rises on the same edge the bit changes.
        pdm_clk_d   = en && (div_cnt_d < DIV_HALF);
        active_d    = load ? hold_q : active_q;
        hold_d      = accept ? {~sample_in[15], sample_in[14:0]} : hold_q;
        hold_full_d = accept || (hold_full_q && !load);
        done_d      = load;
        underrun_d  = boundary && !hold_full_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            active_q    <= 16'h8000;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            pdm_out_q   <= 1'b0;
            pdm_clk_q   <= 1'b0;
            pdm_sd_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            active_q    <= active_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pdm_out_q   <= pdm_out_d;
            pdm_clk_q   <= pdm_clk_d;
            pdm_sd_q    <= en;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign pdm_out      = pdm_out_q;
    assign pdm_clk      = pdm_clk_q;
    assign pdm_sd       = pdm_sd_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_pdm_audio_out.sv
// tb_pdm_audio_out: directed bench; bit patterns per sample window are hand-computed
// for CLK_DIV=4, OSR=16 with the accumulator returned to zero between tests.
module tb_pdm_audio_out;
    logic        clk, reset, en, sample_valid;
    logic [15:0] sample_in;
    logic        sample_ready, pdm_out, pdm_clk, pdm_sd, done, underrun;
    logic        pclk;
    logic [15:0] tx_q[$];
    int          n_cmp, n_bad, n_acc;

    pdm_audio_out #(.CLK_DIV(4), .OSR(16)) dut (
        .clk(clk), .reset(reset), .en(en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .pdm_out(pdm_out), .pdm_clk(pdm_clk), .pdm_sd(pdm_sd),
        .done(done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void drive();
        sample_valid = tx_q.size() != 0;
        sample_in    = (tx_q.size() != 0) ? tx_q[0] : 16'h0;
    endfunction

    task automatic send(input logic [15:0] v);
        tx_q.push_back(v);
        drive();
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        logic prdy;
        pclk = pdm_clk;
        prdy = sample_ready;
        @(negedge clk);
        if (sample_valid && prdy && !reset) begin
            void'(tx_q.pop_front());
            n_acc++;
        end
        drive();
    endtask

    task automatic run_bnd(output logic [15:0] bits, output int nb, output int nc,
                           output int nd, output int nu, output int nr);
        bits = '0; nb = 0; nc = 0; nd = 0; nu = 0; nr = 0;
        while (nd + nu == 0 && nc < 300) begin
            step();
            nc++;
            if (pdm_clk && !pclk) begin
                if (nb < 16) bits[nb] = pdm_out;
                nb++;
            end
            nd += int'(done);
            nu += int'(underrun);
            nr += int'(sample_ready);
        end
        if (nd + nu == 0) chk("bnd_timeout", 32'(nc), 32'(0));
    endtask

    task automatic win(input string t, input logic [15:0] eb, input int end_, input int eu, input int er);
        logic [15:0] b;
        int nb, nc, nd, nu, nr;
        run_bnd(b, nb, nc, nd, nu, nr);
        chk({t, "_bits"}, 32'(b), 32'(eb));
        chk({t, "_nbits"}, 32'(nb), 32'(16));
        chk({t, "_cycles"}, 32'(nc), 32'(64));
        chk({t, "_done"}, 32'(nd), 32'(end_));
        chk({t, "_underrun"}, 32'(nu), 32'(eu));
        chk({t, "_ready_cyc"}, 32'(nr), 32'(er));
    endtask

    task automatic post_rst(input string t);
        logic [7:0] cv, ov;
        for (int i = 0; i < 8; i++) begin
            step();
            cv[i] = pdm_clk;
            ov[i] = pdm_out;
            if (i == 0) chk({t, "_pdm_sd"}, 32'(pdm_sd), 32'(1));
        end
        chk({t, "_clk_seq"}, 32'(cv), 32'h99);
        chk({t, "_out_seq"}, 32'(ov), 32'h80);
    endtask

    task automatic partial(input string t, input logic [15:0] eb, input int ebits, input int ecyc,
                           input int end_, input int eu);
        logic [15:0] b;
        int nb, nc, nd, nu, nr;
        run_bnd(b, nb, nc, nd, nu, nr);
        chk({t, "_bits"}, 32'(b), 32'(eb));
        chk({t, "_nbits"}, 32'(nb), 32'(ebits));
        chk({t, "_cycles"}, 32'(nc), 32'(ecyc));
        chk({t, "_done"}, 32'(nd), 32'(end_));
        chk({t, "_underrun"}, 32'(nu), 32'(eu));
    endtask

    initial begin
        logic bad;
        int acc0;
        n_cmp = 0; n_bad = 0; n_acc = 0;
        reset = 1'b1; en = 1'b1; pclk = 1'b0;
        drive();
        repeat (3) step();
        chk("rst_pdm_out", 32'(pdm_out), 32'(0));
        chk("rst_pdm_clk", 32'(pdm_clk), 32'(0));
        chk("rst_pdm_sd", 32'(pdm_sd), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_underrun", 32'(underrun), 32'(0));
        chk("rst_ready", 32'(sample_ready), 32'(1));
        reset = 1'b0;
        post_rst("start");
        partial("first", 16'h2AAA, 14, 56, 0, 1);
        win("silence", 16'hAAAA, 0, 1, 64);
        chk("ready_idle", 32'(sample_ready), 32'(1));
        send(16'h8000);
        win("ld8000", 16'hAAAA, 1, 0, 1);
        send(16'h7FFF);
        win("neg_fs", 16'h0000, 1, 0, 1);
        send(16'h8001);
        win("pos_fs", 16'hFFFE, 1, 0, 1);
        send(16'h4000);
        win("acc_ret0", 16'h8000, 1, 0, 1);
        win("q34", 16'hEEEE, 0, 1, 64);
        win("repeat", 16'hEEEE, 0, 1, 64);
        acc0 = n_acc;
        send(16'h8000); send(16'hC000); send(16'h0000); send(16'h4000);
        win("st_rep", 16'hEEEE, 1, 0, 1);
        win("st0", 16'h0000, 1, 0, 1);
        win("st1", 16'h8888, 1, 0, 1);
        win("st2", 16'hAAAA, 1, 0, 1);
        win("st3", 16'hEEEE, 0, 1, 64);
        chk("st_accepts", 32'(n_acc - acc0), 32'(4));
        repeat (10) step();
        en = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            step();
            bad = bad | pdm_out | pdm_clk | pdm_sd | done | underrun;
        end
        chk("en_low_quiet", 32'(bad), 32'(0));
        en = 1'b1;
        partial("resume", 16'h3BBB, 14, 54, 0, 1);
        send(16'h7FFF);
        repeat (20) step();
        chk("pre_rst_ready", 32'(sample_ready), 32'(0));
        reset = 1'b1;
        step();
        chk("mid_rst_out", 32'(pdm_out), 32'(0));
        chk("mid_rst_clk", 32'(pdm_clk), 32'(0));
        chk("mid_rst_sd", 32'(pdm_sd), 32'(0));
        chk("mid_rst_pulses", 32'(done | underrun), 32'(0));
        chk("mid_rst_ready", 32'(sample_ready), 32'(1));
        reset = 1'b0;
        post_rst("rerun");
        partial("discard", 16'h2AAA, 14, 56, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
